// File: rtl/prog_freq_div_pkg.sv
// prog_freq_div_pkg: shared constants and helpers for the programmable divider.
//   MODE_TOGGLE / MODE_PULSE : per-channel output mode encodings
//   DEFAULT_DIV_C            : divisor loaded on reset (matches the legacy divider)
//   sel_width()              : channel-select width, clog2 with a floor of 1
package prog_freq_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int unsigned DEFAULT_DIV_C = 25000000;

  // A single-channel build still needs a 1-bit select port.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_channel.sv
// div_channel: one divider channel with a glitch-free reprogrammable divisor.
//   clk, clr : clock and synchronous active-high reset
//   en       : channel enable; when low the counter and outputs are held at 0
//   mode     : 0 = toggle (square wave), 1 = pulse (one-cycle strobe)
//   we, val  : divisor write for this channel
//   clkout   : square wave or strobe depending on mode
//   tick     : one-cycle strobe at every terminal count
module div_channel
  import prog_freq_div_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             mode,
  input  logic             we,
  input  logic [WIDTH-1:0] val,
  output logic             clkout,
  output logic             tick
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] shadow;
  logic             pending;
  logic             mode_q;
  logic             tc;

  assign tc = en && (cnt == active);

  // Counter, divisor staging and registered outputs. The active divisor only
  // changes while the counter is at 0 (disabled) or at a terminal count, so
  // cnt can never run past active and no period is ever cut short or stretched.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt     <= '0;
      active  <= DEF;
      shadow  <= DEF;
      pending <= 1'b0;
      tick    <= 1'b0;
      clkout  <= 1'b0;
      mode_q  <= MODE_TOGGLE;
    end else begin
      mode_q <= mode;
      if (we) shadow <= val;

      if (!en) begin
        // No period in flight, so any new or staged divisor applies at once.
        cnt     <= '0;
        tick    <= 1'b0;
        clkout  <= 1'b0;
        pending <= 1'b0;
        if (we) active <= val;
        else if (pending) active <= shadow;
      end else begin
        tick <= tc;
        if (tc) begin
          // A write landing on the TC itself governs the very next period.
          cnt     <= '0;
          pending <= 1'b0;
          if (we) active <= val;
          else if (pending) active <= shadow;
        end else begin
          cnt <= cnt + WIDTH'(1);
          if (we) pending <= 1'b1;
        end

        // Entering toggle mode from pulse mode restarts the wave from low.
        if (mode == MODE_PULSE) clkout <= tc;
        else if (mode_q == MODE_PULSE) clkout <= 1'b0;
        else if (tc) clkout <= ~clkout;
      end
    end
  end

endmodule

// File: rtl/prog_freq_div.sv
// prog_freq_div: multi-channel runtime-programmable tick / square-wave divider.
//   clk, clr          : clock and synchronous active-high reset
//   en[NCH]           : per-channel enable
//   mode[NCH]         : per-channel mode, 0 = toggle, 1 = pulse
//   div_we            : divisor write strobe
//   div_sel[SELW]     : channel addressed by the write (>= NCH is ignored)
//   div_val[WIDTH]    : divisor value
//   clkout[NCH]       : per-channel level or strobe
//   tick[NCH]         : per-channel terminal-count strobe
module prog_freq_div
  import prog_freq_div_pkg::*;
#(
  parameter  int          WIDTH       = 32,
  parameter  int          NCH         = 4,
  parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_C,
  localparam int          SELW        = sel_width(NCH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   mode,
  input  logic             div_we,
  input  logic [SELW-1:0]  div_sel,
  input  logic [WIDTH-1:0] div_val,
  output logic [NCH-1:0]   clkout,
  output logic [NCH-1:0]   tick
);

  logic [NCH-1:0] wr_en;

  // Out-of-range selects match no channel, so such writes are dropped.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_en[i] = div_we && (div_sel == SELW'(i));
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    div_channel #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk   (clk),
      .clr   (clr),
      .en    (en[i]),
      .mode  (mode[i]),
      .we    (wr_en[i]),
      .val   (div_val),
      .clkout(clkout[i]),
      .tick  (tick[i])
    );
  end

endmodule

// File: tb/tb_prog_freq_div.sv
// tb_prog_freq_div: randomized scoreboard bench for prog_freq_div.
// Two instances: a 4-channel one and a 3-channel one (the latter exercises
// out-of-range selects). A countdown reference model predicts every cycle's
// outputs; a separate monitor pops and compares them.
module tb_prog_freq_div;
  import prog_freq_div_pkg::*;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] en;
  logic [3:0] mode;
  logic       we_a;
  logic [1:0] sel_a;
  logic [7:0] val_a;
  logic       we_b;
  logic [1:0] sel_b;
  logic [7:0] val_b;
  logic [3:0] clkout_a, tick_a;
  logic [2:0] clkout_b, tick_b;

  typedef struct packed {
    logic [3:0] ck_a;
    logic [3:0] tk_a;
    logic [2:0] ck_b;
    logic [2:0] tk_b;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Reference model state, channels 0..3 = instance A, 4..6 = instance B.
  int m_d[7];
  int m_next[7];
  int m_rem[7];
  int m_tog[7];
  bit m_prev[7];
  bit m_ck[7];
  bit m_tk[7];

  prog_freq_div #(.WIDTH(8), .NCH(4), .DEFAULT_DIV(3)) dut_a (
    .clk(clk), .clr(clr), .en(en), .mode(mode),
    .div_we(we_a), .div_sel(sel_a), .div_val(val_a),
    .clkout(clkout_a), .tick(tick_a)
  );

  prog_freq_div #(.WIDTH(8), .NCH(3), .DEFAULT_DIV(3)) dut_b (
    .clk(clk), .clr(clr), .en(en[2:0]), .mode(mode[2:0]),
    .div_we(we_b), .div_sel(sel_b), .div_val(val_b),
    .clkout(clkout_b), .tick(tick_b)
  );

  initial forever #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    for (int i = 0; i < 7; i++) begin
      int ch;
      bit e, md, w, tc;
      int v;
      ch = (i < 4) ? i : i - 4;
      e  = en[ch];
      md = mode[ch];
      if (i < 4) begin
        w = we_a && (int'(sel_a) == i);
        v = int'(val_a);
      end else begin
        w = we_b && (int'(sel_b) == i - 4);
        v = int'(val_b);
      end
      if (clr) begin
        m_d[i] = 3; m_next[i] = -1; m_rem[i] = 3; m_tog[i] = 0;
        m_prev[i] = 1'b0; m_ck[i] = 1'b0; m_tk[i] = 1'b0;
      end else begin
        if (!e) begin
          if (w) m_d[i] = v;
          else if (m_next[i] >= 0) m_d[i] = m_next[i];
          m_next[i] = -1;
          m_rem[i]  = m_d[i];
          m_tk[i]   = 1'b0;
          m_ck[i]   = 1'b0;
          m_tog[i]  = 0;
        end else begin
          tc = (m_rem[i] == 0);
          if (tc) begin
            if (w) m_d[i] = v;
            else if (m_next[i] >= 0) m_d[i] = m_next[i];
            m_next[i] = -1;
            m_rem[i]  = m_d[i];
          end else begin
            m_rem[i] = m_rem[i] - 1;
            if (w) m_next[i] = v;
          end
          m_tk[i] = tc;
          if (md) m_ck[i] = tc;
          else if (m_prev[i]) begin
            m_tog[i] = 0;
            m_ck[i]  = 1'b0;
          end else begin
            if (tc) m_tog[i] = m_tog[i] + 1;
            m_ck[i] = (m_tog[i] % 2) == 1;
          end
        end
        m_prev[i] = md;
      end
    end
  endtask

  // Drive one cycle of inputs, run the model and queue the expected outputs.
  task automatic applyStimulus(input bit do_clr, input bit randomize_in);
    exp_t x;
    clr = do_clr;
    if (randomize_in) begin
      if ($urandom_range(0, 199) == 0) clr = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 29) == 0) mode[c] = ~mode[c];
      end
      we_a  = ($urandom_range(0, 5) == 0);
      sel_a = 2'($urandom_range(0, 3));
      val_a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
      we_b  = ($urandom_range(0, 5) == 0);
      sel_b = 2'($urandom_range(0, 3));
      val_b = 8'($urandom_range(0, 6));
    end else begin
      we_a = 1'b0;
      we_b = 1'b0;
    end
    model_step();
    for (int i = 0; i < 4; i++) begin
      x.ck_a[i] = m_ck[i];
      x.tk_a[i] = m_tk[i];
    end
    for (int i = 0; i < 3; i++) begin
      x.ck_b[i] = m_ck[i+4];
      x.tk_b[i] = m_tk[i+4];
    end
    sb.push_back(x);
  endtask

  task automatic checkOutput(input exp_t x);
    tests_run += 4;
    if (clkout_a !== x.ck_a) begin
      tests_failed++;
      $display("[TB] FAIL clkout_a at %0t: got %b expected %b", $time, clkout_a, x.ck_a);
    end
    if (tick_a !== x.tk_a) begin
      tests_failed++;
      $display("[TB] FAIL tick_a at %0t: got %b expected %b", $time, tick_a, x.tk_a);
    end
    if (clkout_b !== x.ck_b) begin
      tests_failed++;
      $display("[TB] FAIL clkout_b at %0t: got %b expected %b", $time, clkout_b, x.ck_b);
    end
    if (tick_b !== x.tk_b) begin
      tests_failed++;
      $display("[TB] FAIL tick_b at %0t: got %b expected %b", $time, tick_b, x.tk_b);
    end
  endtask

  // Monitor: outputs are valid every cycle; sample away from the rising edge.
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checkOutput(x);
      end
    end
  end

  initial begin : driver
    en    = 4'h0;
    mode  = 4'h0;
    we_a  = 1'b0; sel_a = 2'd0; val_a = 8'd0;
    we_b  = 1'b0; sel_b = 2'd0; val_b = 8'd0;
    applyStimulus(1'b1, 1'b0);
    @(posedge clk); #2;
    applyStimulus(1'b1, 1'b0);
    en = 4'hF;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #2;
      applyStimulus(1'b0, 1'b0);
    end
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #2;
      applyStimulus(1'b0, 1'b1);
    end
    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/prog_freq_div.md
Name: prog_freq_div

Overview:
- Multi-channel, runtime-programmable clock/tick divider; successor to the fixed 25 MHz-count single-output divider.
- Each channel has its own divisor register, enable and output mode.
- Supplies slow strobes and square waves to display scanning, debouncing, stopwatch and FSM pacing logic.
- Single clock domain; outputs are registered enables/levels, not clocks for other flops.

Parameters:
- WIDTH, 32, counter and divisor width in bits.
- NCH, 4, number of independent channels (1..16).
- DEFAULT_DIV, 25000000, divisor loaded into every channel on reset.
- SELW, $clog2(NCH) (min 1), width of the channel-select port; derived, not overridden.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset; synchronous, active-high.
- en  in  NCH  per-channel enable.
- mode  in  NCH  per-channel output mode: 0 = toggle (square wave), 1 = pulse (one-cycle strobe).
- div_we  in  1  divisor write strobe.
- div_sel  in  SELW  channel addressed by the write.
- div_val  in  WIDTH  divisor value to write.
- clkout  out  NCH  per-channel output (level or strobe, per mode).
- tick  out  NCH  per-channel one-cycle terminal-count strobe, independent of mode.

Behaviour:
- Reset (clr=1 at posedge clk):
  - all counters = 0; clkout = 0; tick = 0.
  - active and shadow divisors = DEFAULT_DIV; pending flags = 0.
  - clr has priority over every other input, including mid-period and mid-write.
- Counting (en[i]=1):
  - cnt[i] increments each cycle.
  - When cnt[i] == div_active[i] (terminal count, TC): cnt[i] <= 0 and tick[i] <= 1 for exactly one cycle.
  - Period between TCs = D+1 cycles.
  - Toggle mode: clkout[i] inverts at each TC; full period = 2*(D+1) cycles; the DEFAULT_DIV setting matches the legacy divider.
  - Pulse mode: clkout[i] equals tick[i], registered on the same edge.
- D = 0: TC every cycle; tick is held high continuously; toggle-mode clkout = clk/2.
- Disabled (en[i]=0):
  - cnt[i] held at 0; clkout[i] = 0; tick[i] = 0.
  - On re-enable, counting restarts from 0; first TC arrives D+1 cycles after the en rising edge.
- Mode change mid-period: takes effect on the next cycle.
  - Switching toggle->pulse forces clkout to the pulse value (0 except at TC).
  - Switching pulse->toggle starts from clkout = 0.
- Divisor write (div_we=1, div_sel=k < NCH):
  - div_val is captured into shadow[k] and pending[k] is set.
  - If channel k is disabled: active[k] <= div_val immediately; pending cleared.
  - If enabled: active[k] <= shadow[k] at the next TC, so periods are glitch-free; the current period finishes with the old D.
  - Write on the same cycle as a TC of channel k: the new value loads at that TC and governs the very next period.
  - Back-to-back writes before a TC: the last value wins.
  - div_sel >= NCH: write ignored, no state changes.
- Width rules: compare is unsigned WIDTH bits; no overflow is possible because cnt never exceeds active.
- Latency: div_we to new period start is at most D_old+1 cycles; en to first tick is D+1 cycles.

Decomposition:
- Shared package prog_freq_div_pkg:
  - MODE_TOGGLE = 1'b0, MODE_PULSE = 1'b1.
  - default divisor constant.
  - SELW helper function (clog2 with min 1).
- One sub-module, div_channel:
  - holds counter, active/shadow divisor, pending flag and output logic.
  - instantiated NCH times via generate.
  - top level only decodes div_we/div_sel into per-channel write enables.

Test Plan:
- Reset/default: NCH=4, WIDTH=8, DEFAULT_DIV=3, all en=1, mode=0 -> tick every 4 cycles on all channels; clkout toggles every 4 cycles (period 8); clr pulse mid-period -> all outputs 0 next cycle, and the first tick lands 4 cycles after clr deasserts.
- Live reprogram: ch1 running D=3; write div_val=1 at cnt=1 -> the remaining ticks at D=3 spacing continue until the next TC, then ticks every 2 cycles; no short or long period is observed.
- Disabled write and re-enable: en[2]=0, write 5 to ch2 -> active takes the value immediately; raise en[2] -> first tick 6 cycles later, then every 6 cycles.
- Pulse mode and D=0: ch3 mode=1, D=0 -> tick and clkout held high every cycle; switch to mode=0 -> clkout toggles each cycle starting from 0.
- Write/TC collision and invalid select: write 2 to ch0 on its TC cycle -> the next period is 3 cycles; NCH=3 instance with div_sel=3 write -> no channel's period changes.
- Disable mid-period: drop en[0] at cnt=2 -> clkout and tick 0 next cycle, cnt held at 0; re-enable -> full D+1 period before the first tick.
